// File: rtl/sha256_job_scheduler_if.sv
// Purpose: bundles the requester and SHA-256 core signals of the job scheduler.
// Latency: none, wiring only.
// Backpressure: req_valid is held until req_accept; core pulses wait for core_ready; responses have none.
interface sha256_job_scheduler_if #(
  parameter int IDX_W = 8,
  parameter int DIG_W = 256
);
  // requester side
  logic [1:0]         req_valid;
  logic [2*IDX_W-1:0] req_first;
  logic [2*IDX_W-1:0] req_count;
  logic [1:0]         req_accept;
  // compression core side
  logic               core_init;
  logic               core_next;
  logic [IDX_W-1:0]   core_block_idx;
  logic               core_ready;
  logic [DIG_W-1:0]   core_digest;
  logic               core_digest_valid;
  // response side
  logic               rsp_valid;
  logic               rsp_id;
  logic               rsp_error;
  logic [DIG_W-1:0]   rsp_digest;
  logic               busy;

  // environment view: requesters plus the compression core
  modport master (
    output req_valid, req_first, req_count, core_ready, core_digest, core_digest_valid,
    input  req_accept, core_init, core_next, core_block_idx,
    input  rsp_valid, rsp_id, rsp_error, rsp_digest, busy
  );

  // scheduler view
  modport slave (
    input  req_valid, req_first, req_count, core_ready, core_digest, core_digest_valid,
    output req_accept, core_init, core_next, core_block_idx,
    output rsp_valid, rsp_id, rsp_error, rsp_digest, busy
  );
endinterface

// File: rtl/sha256_job_scheduler.sv
// Purpose: round-robin sharing of one SHA-256 core between two requesters, walking ROM block runs.
// Latency: accept at t, first core pulse at t+1, response one cycle after the last digest (t+1 for count 0).
// Backpressure: requests wait in IDLE until granted; ISSUE stalls on core_ready; responses cannot be stalled.
module sha256_job_scheduler #(
  parameter int IDX_W       = 8,
  parameter int DIG_W       = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  rst,
  sha256_job_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic             last_grant;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] remaining;
  logic             id_q;
  logic             first_blk;
  logic             err_q;
  logic [WD_W-1:0]  wd_cnt;
  logic [DIG_W-1:0] dig_q;

  logic             gnt_vld;
  logic             gnt_id;
  logic [IDX_W-1:0] gnt_first;
  logic [IDX_W-1:0] gnt_count;
  logic             wd_expire;
  logic             issue_fire;

  // Arbitration and issue qualification; a tie goes to the requester not granted last.
  // Accept is gated by rst so it stays low while reset is held.
  always_comb begin
    gnt_vld    = (state == IDLE) && rst && (bus.req_valid != 2'b00);
    gnt_id     = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
    gnt_first  = gnt_id ? bus.req_first[2*IDX_W-1:IDX_W] : bus.req_first[IDX_W-1:0];
    gnt_count  = gnt_id ? bus.req_count[2*IDX_W-1:IDX_W] : bus.req_count[IDX_W-1:0];
    wd_expire  = ((state == ISSUE) || (state == WAIT)) && (wd_cnt == WD_LAST);
    issue_fire = (state == ISSUE) && bus.core_ready && !wd_expire;
  end

  assign bus.req_accept     = gnt_vld ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.core_init      = issue_fire && first_blk;
  assign bus.core_next      = issue_fire && !first_blk;
  // cur_idx only moves on a digest, so the index is stable from pulse to digest
  assign bus.core_block_idx = cur_idx;
  assign bus.rsp_valid      = (state == DONE);
  assign bus.rsp_id         = id_q;
  assign bus.rsp_error      = err_q;
  assign bus.rsp_digest     = dig_q;
  assign bus.busy           = (state != IDLE);

  // Job state machine: latch on grant, issue/wait per block, watchdog, single-cycle response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_idx    <= '0;
      remaining  <= '0;
      id_q       <= 1'b0;
      first_blk  <= 1'b0;
      err_q      <= 1'b0;
      wd_cnt     <= '0;
      dig_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            cur_idx    <= gnt_first;
            remaining  <= gnt_count;
            id_q       <= gnt_id;
            first_blk  <= 1'b1;
            last_grant <= gnt_id;
            wd_cnt     <= '0;
            if (gnt_count == '0) begin
              err_q <= 1'b1;
              dig_q <= '0;
              state <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (wd_expire) begin
            err_q <= 1'b1;
            dig_q <= '0;
            state <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (bus.core_ready) begin
              first_blk <= 1'b0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // a digest arriving in the expiry cycle still completes the block
          if (bus.core_digest_valid) begin
            remaining <= remaining - 1'b1;
            if (remaining == IDX_W'(1)) begin
              dig_q <= bus.core_digest;
              err_q <= 1'b0;
              state <= DONE;
            end else begin
              cur_idx <= cur_idx + 1'b1;
              wd_cnt  <= '0;
              state   <= ISSUE;
            end
          end else if (wd_expire) begin
            err_q <= 1'b1;
            dig_q <= '0;
            state <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Purpose: directed bench for sha256_job_scheduler with a fixed-latency core model.
// Latency: core model returns a digest LAT cycles after each init/next pulse.
// Backpressure: requesters hold req_valid until accepted; core_ready is driven by the stimulus.
module tb_sha256_job_scheduler;
  localparam int IDX_W = 8;
  localparam int DIG_W = 256;
  localparam int TO    = 1024;
  localparam int LAT   = 3;
  localparam logic [255:0] ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  sha256_job_scheduler_if #(.IDX_W(IDX_W), .DIG_W(DIG_W)) bus ();

  sha256_job_scheduler #(.IDX_W(IDX_W), .DIG_W(DIG_W), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // cycle index, read at the falling edge
  always @(posedge clk) cyc++;

  // observation logs
  int           n_rsp = 0;
  int           n_both = 0;
  int           lat_cnt = 0;
  bit           spur = 1'b0;
  logic [255:0] acc_dig;
  bit           grant_q[$];
  int           acc_cyc_q[$];
  bit           pkind_q[$];
  logic [7:0]   pidx_q[$];
  bit           rid_q[$];
  bit           rerr_q[$];
  logic [255:0] rdig_q[$];
  int           rcyc_q[$];

  // Falling-edge monitor and core model: log accepts/pulses/responses, then drive the digest.
  always @(negedge clk) begin
    if (!rst) begin
      lat_cnt = 0;
      bus.core_digest_valid = 1'b0;
      bus.core_digest = '0;
    end else begin
      if (bus.req_accept != 2'b00) begin
        grant_q.push_back(bus.req_accept[1]);
        acc_cyc_q.push_back(cyc);
      end
      if (bus.rsp_valid) begin
        rid_q.push_back(bus.rsp_id);
        rerr_q.push_back(bus.rsp_error);
        rdig_q.push_back(bus.rsp_digest);
        rcyc_q.push_back(cyc);
        n_rsp++;
      end
      if (bus.core_init && bus.core_next) n_both++;
      bus.core_digest_valid = spur;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.core_digest_valid = 1'b1;
          bus.core_digest = acc_dig;
        end
      end
      if (bus.core_init || bus.core_next) begin
        pkind_q.push_back(bus.core_init);
        pidx_q.push_back(bus.core_block_idx);
        lat_cnt = LAT;
        if (bus.core_init)
          acc_dig = (bus.core_block_idx == 8'd0) ? ABC :
                    (bus.core_block_idx == 8'd2) ? EMPTY : {248'h0, bus.core_block_idx};
        else
          acc_dig = {acc_dig[247:0], bus.core_block_idx};
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] first, input logic [7:0] count);
    bus.req_first[i*8 +: 8] = first;
    bus.req_count[i*8 +: 8] = count;
  endtask

  // Raise the masked requests and drop each one after the edge that accepted it.
  task automatic drive(input logic [1:0] mask);
    int seen;
    @(posedge clk); #1;
    seen = grant_q.size();
    bus.req_valid = mask;
    for (int n = 0; n < 200 && bus.req_valid != 2'b00; n++) begin
      @(posedge clk); #1;
      while (seen < grant_q.size()) begin
        bus.req_valid[grant_q[seen]] = 1'b0;
        seen++;
      end
    end
    chk("accept_pending", bus.req_valid, 2'b00);
    bus.req_valid = 2'b00;
  endtask

  task automatic wait_rsp(input int target, input int max);
    for (int n = 0; n < max && n_rsp < target; n++) @(posedge clk);
    #1;
    chk("rsp_count", n_rsp, target);
  endtask

  function automatic int last_acc();
    return acc_cyc_q[acc_cyc_q.size()-1];
  endfunction

  initial begin
    int r0;
    int p0;
    int g0;
    bus.req_valid = 2'b00;
    bus.req_first = '0;
    bus.req_count = '0;
    bus.core_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_accept", bus.req_accept, 2'b00);
    chk("reset_core_pulse", {bus.core_init, bus.core_next}, 2'b00);
    chk("reset_digest", bus.rsp_digest, 256'h0);
    chk("reset_error", bus.rsp_error, 1'b0);
    chk("reset_idx", bus.core_block_idx, 8'h00);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;

    // simultaneous first requests after reset: requester 0 wins
    set_req(0, 8'd0, 8'd1);
    set_req(1, 8'd2, 8'd1);
    drive(2'b11);
    wait_rsp(2, 100);
    chk("tie_first_grant", grant_q[0], 1'b0);
    chk("tie_second_grant", grant_q[1], 1'b1);
    chk("abc_id", rid_q[0], 1'b0);
    chk("abc_err", rerr_q[0], 1'b0);
    chk("abc_digest", rdig_q[0], ABC);
    chk("abc_latency", rcyc_q[0] - acc_cyc_q[0], 2 + LAT);
    chk("empty_id", rid_q[1], 1'b1);
    chk("empty_err", rerr_q[1], 1'b0);
    chk("empty_digest", rdig_q[1], EMPTY);

    // single block, requester 0: one init at index 0, no next
    r0 = n_rsp;
    p0 = pidx_q.size();
    set_req(0, 8'd0, 8'd1);
    drive(2'b01);
    wait_rsp(r0 + 1, 100);
    chk("single_pulses", pidx_q.size() - p0, 1);
    chk("single_kind_init", pkind_q[p0], 1'b1);
    chk("single_idx", pidx_q[p0], 8'd0);
    chk("single_latency", rcyc_q[r0] - last_acc(), 2 + LAT);
    chk("single_digest", rdig_q[r0], ABC);

    // repeat tie after requester 0 was granted: requester 1 first
    g0 = grant_q.size();
    drive(2'b11);
    wait_rsp(r0 + 3, 100);
    chk("alt_first_grant", grant_q[g0], 1'b1);
    chk("alt_second_grant", grant_q[g0+1], 1'b0);
    chk("alt_first_digest", rdig_q[r0+1], EMPTY);

    // three blocks wrapping the index: init 254, next 255, next 0
    r0 = n_rsp;
    p0 = pidx_q.size();
    set_req(1, 8'd254, 8'd3);
    drive(2'b10);
    wait_rsp(r0 + 1, 100);
    repeat (10) @(posedge clk);
    #1;
    chk("wrap_one_rsp", n_rsp, r0 + 1);
    chk("wrap_pulses", pidx_q.size() - p0, 3);
    chk("wrap_kinds", {pkind_q[p0], pkind_q[p0+1], pkind_q[p0+2]}, 3'b100);
    chk("wrap_idx", {pidx_q[p0], pidx_q[p0+1], pidx_q[p0+2]}, 24'hFEFF00);
    chk("wrap_id", rid_q[r0], 1'b1);
    chk("wrap_digest", rdig_q[r0], 256'hFEFF00);
    chk("wrap_latency", rcyc_q[r0] - last_acc(), 3 * (1 + LAT) + 1);

    // zero count: error response one cycle after accept, no pulses
    r0 = n_rsp;
    p0 = pidx_q.size();
    set_req(0, 8'd9, 8'd0);
    drive(2'b01);
    wait_rsp(r0 + 1, 20);
    chk("zero_latency", rcyc_q[r0] - last_acc(), 1);
    chk("zero_err", rerr_q[r0], 1'b1);
    chk("zero_digest", rdig_q[r0], 256'h0);
    chk("zero_pulses", pidx_q.size() - p0, 0);

    // stray digest_valid while idle is ignored
    r0 = n_rsp;
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_busy", bus.busy, 1'b0);
    chk("stray_no_rsp", n_rsp, r0);

    // watchdog: core never ready
    r0 = n_rsp;
    p0 = pidx_q.size();
    bus.core_ready = 1'b0;
    set_req(0, 8'd5, 8'd1);
    drive(2'b01);
    wait_rsp(r0 + 1, TO + 50);
    chk("wd_err", rerr_q[r0], 1'b1);
    chk("wd_digest", rdig_q[r0], 256'h0);
    chk("wd_latency", rcyc_q[r0] - last_acc(), TO + 1);
    chk("wd_pulses", pidx_q.size() - p0, 0);
    bus.core_ready = 1'b1;

    // reset during WAIT: outputs clear at once, no response
    r0 = n_rsp;
    set_req(0, 8'd0, 8'd1);
    drive(2'b01);
    @(posedge clk); #3;
    chk("pre_reset_busy", bus.busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_reset_busy", bus.busy, 1'b0);
    chk("mid_reset_pulse", {bus.core_init, bus.core_next}, 2'b00);
    chk("mid_reset_rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_id}, 3'b000);
    chk("mid_reset_idx", bus.core_block_idx, 8'h00);
    chk("mid_reset_digest", bus.rsp_digest, 256'h0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("aborted_no_rsp", n_rsp, r0);
    drive(2'b01);
    wait_rsp(r0 + 1, 100);
    chk("post_reset_id", rid_q[r0], 1'b0);
    chk("post_reset_err", rerr_q[r0], 1'b0);
    chk("post_reset_digest", rdig_q[r0], ABC);

    chk("init_next_overlap", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish before 1000000");
    $fatal(1, "global timeout");
  end
endmodule
